cic_capture_buf: RTL
====================

Name: cic_capture_buf

Overview:
- Triggered waveform recorder that sits directly downstream of the first-order CIC decimator.
- Consumes the decimated sample stream (data / gate pair) and holds a circular history of 2^aw samples.
- On a trigger, freezes a record containing a programmable number of pre-trigger samples plus post-trigger samples.
- Host readout is random access, relative to the oldest sample of the record.

Parameters:
- dw, 16, sample width (matches decimator output width)
- aw, 10, record depth is 2^aw samples

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  dw  decimated sample, unsigned, valid when data_in_gate=1
- data_in_gate  in  1  single-cycle sample strobe from decimator
- arm  in  1  single-cycle pulse: latch pretrig, start new capture
- trig  in  1  trigger, qualified by data_in_gate
- pretrig  in  aw  number of pre-trigger samples, 0..2^aw-1, latched on arm
- busy  out  1  capture in progress (FILL, ARMED or POST)
- ready  out  1  record complete and frozen (DONE)
- rd_addr  in  aw  readout index, 0 = oldest sample of record
- rd_data  out  dw  registered read data

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; busy=0, ready=0, rd_data=0.
  - wr_ptr, start_ptr and all counters = 0.
  - RAM contents are not reset.
- States and transitions:
  - IDLE: no writes. Goes to FILL on arm.
  - FILL: write each gated sample at wr_ptr, then wr_ptr++ (mod 2^aw); fill_cnt++. Goes to ARMED when fill_cnt reaches the latched pretrig. If pretrig=0, arm goes straight to ARMED.
  - ARMED: keep writing. On a gated cycle with trig=1:
    - the sample on that cycle is the trigger sample;
    - start_ptr <= wr_ptr - pretrig (mod 2^aw);
    - post_cnt <= 1;
    - go to POST.
  - POST: keep writing; post_cnt++ each gated sample. After the gated write that makes post_cnt = 2^aw - pretrig (trigger sample counts as 1), go to DONE.
  - DONE: no writes; record frozen until the next arm.
- Trigger sample lands at rd_addr = pretrig.
- Record layout: rd_addr 0..pretrig-1 are pre-trigger samples; pretrig..2^aw-1 are the trigger sample and post-trigger samples.
- trig is ignored in IDLE, FILL, POST and DONE, and on any cycle without data_in_gate.
- arm in any state: restarts the capture, relatches pretrig, clears counters and ready; wr_ptr is not cleared.
- arm and trig in the same cycle: arm wins, trig ignored.
- arm coincident with data_in_gate: that sample is not written (the new capture starts on the next gate).
- Outputs: busy and ready are registered state decodes. ready rises on the clk edge that completes the final gated write.
- Readout:
  - physical address = start_ptr + rd_addr (mod 2^aw);
  - rd_data valid one clk after rd_addr (1-cycle registered RAM read);
  - reads are legal in any state but defined only when ready=1.
- Arithmetic: pointers and counters are aw bits, modulo 2^aw. post_cnt is aw+1 bits so it can reach 2^aw when pretrig=0. No sample arithmetic; data is stored verbatim.
- Wrap-around: ARMED may last indefinitely; writes overwrite the oldest entries.
- Reset mid-capture returns to IDLE immediately; ready stays 0 until a full new capture completes.

Test Plan (dw=16, aw=4, gate every 4th clk, data = ramp incrementing by 1 per gate):
- Reset mid-POST: rst_n=0 -> busy=0, ready=0, rd_data=0 asynchronously. Then arm, pretrig=2, trig on the sample of value 300 -> ready rises; rd_addr 0..15 returns 298..313.
- pretrig=4:
  - arm before sample 100, trig on sample 110 -> busy during capture, ready one edge after the gate of sample 121;
  - rd_addr 0..15 returns 106..121 with 1-cycle latency; rd_addr 4 = 110.
- pretrig=0, trig on the first gated sample 200 after arm -> record 200..215; rd_addr 0 = 200.
- Trig during FILL ignored: pretrig=8, arm before sample 0, trig on sample 1 (ignored) and on sample 20 -> record 12..27.
- arm and trig in the same cycle, then a later trig on sample 50 with pretrig=3 -> first trig ignored; record 47..62. A second arm during POST -> capture restarts, ready stays 0 until the new record completes.
- Wrap: pretrig=15, hold ARMED for 100 samples, trig on sample 140 -> record 125..140; rd_addr 15 = 140; ready after 1 post sample.

Source files
------------

// File: rtl/cic_capture_buf_if.sv
// Sample-stream, trigger-control and readout bundle for the triggered CIC capture buffer.
interface cic_capture_buf_if #(
  parameter int dw = 16,
  parameter int aw = 10
);
  logic [dw-1:0] data_in;
  logic          data_in_gate;
  logic          arm;
  logic          trig;
  logic [aw-1:0] pretrig;
  logic          busy;
  logic          ready;
  logic [aw-1:0] rd_addr;
  logic [dw-1:0] rd_data;

  modport master (
    output data_in, data_in_gate, arm, trig, pretrig, rd_addr,
    input  busy, ready, rd_data
  );

  modport slave (
    input  data_in, data_in_gate, arm, trig, pretrig, rd_addr,
    output busy, ready, rd_data
  );
endinterface

// File: rtl/cic_capture_buf.sv
// Triggered waveform recorder: circular history of decimated samples, frozen around a
// trigger with a programmable pre-trigger depth, read back relative to the oldest sample.
module cic_capture_buf #(
  parameter int dw = 16,
  parameter int aw = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  cic_capture_buf_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [aw-1:0] ONE_A = {{(aw-1){1'b0}}, 1'b1};
  localparam logic [aw:0]   ONE_P = {{aw{1'b0}}, 1'b1};
  localparam logic [aw:0]   DEPTH = {1'b1, {aw{1'b0}}};

  logic [2:0]    state_q,     state_d;
  logic [aw-1:0] wr_ptr_q,    wr_ptr_d;
  logic [aw-1:0] start_ptr_q, start_ptr_d;
  logic [aw-1:0] fill_cnt_q,  fill_cnt_d;
  logic [aw:0]   post_cnt_q,  post_cnt_d;
  logic [aw-1:0] pretrig_q,   pretrig_d;
  logic          busy_q,      busy_d;
  logic          ready_q,     ready_d;
  logic [dw-1:0] rd_data_q;
  logic          wr_en;
  logic [aw:0]   post_target;
  logic [aw-1:0] rd_phys;

  logic [dw-1:0] mem [0:(1<<aw)-1];

  // Samples still owed after the trigger, the trigger sample itself counting as one.
  assign post_target = DEPTH - {1'b0, pretrig_q};
  assign rd_phys     = start_ptr_q + bus.rd_addr;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    post_cnt_d  = post_cnt_q;
    pretrig_d   = pretrig_q;
    wr_en       = 1'b0;

    if (bus.arm) begin
      // arm overrides everything on its cycle, including a coincident sample or trigger
      pretrig_d  = bus.pretrig;
      fill_cnt_d = '0;
      post_cnt_d = '0;
      state_d    = (bus.pretrig == '0) ? S_ARMED : S_FILL;
    end else if (bus.data_in_gate) begin
      case (state_q)
        S_FILL: begin
          wr_en      = 1'b1;
          fill_cnt_d = fill_cnt_q + ONE_A;
          if (fill_cnt_d == pretrig_q) begin
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          wr_en = 1'b1;
          if (bus.trig) begin
            start_ptr_d = wr_ptr_q - pretrig_q;
            post_cnt_d  = ONE_P;
            state_d     = (post_target == ONE_P) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          wr_en      = 1'b1;
          post_cnt_d = post_cnt_q + ONE_P;
          if (post_cnt_d == post_target) begin
            state_d = S_DONE;
          end
        end
        default: begin
        end
      endcase
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ONE_A;
    end
  end

  assign busy_d  = (state_d == S_FILL) || (state_d == S_ARMED) || (state_d == S_POST);
  assign ready_d = (state_d == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      pretrig_q   <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      post_cnt_q  <= post_cnt_d;
      pretrig_q   <= pretrig_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_phys];
    end
  end

  assign bus.busy    = busy_q;
  assign bus.ready   = ready_q;
  assign bus.rd_data = rd_data_q;

endmodule
